// File: rtl/ysyx_23060136_exu2_muldiv_if.sv
// Handshake bundle between the EXU2 stage and its iterative multiply/divide unit.
// The master is the EXU2 side; the slave is the arithmetic unit.
interface ysyx_23060136_exu2_muldiv_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic            op_w;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            stall_req;

  modport master (
    output flush, in_valid, op, op_w, src1, src2, out_ready,
    input  in_ready, out_valid, result, stall_req
  );

  modport slave (
    input  flush, in_valid, op, op_w, src1, src2, out_ready,
    output in_ready, out_valid, result, stall_req
  );
endinterface

// File: rtl/ysyx_23060136_exu2_muldiv.sv
// Iterative radix-2 RV64M multiply/divide unit for EXU2: one product/quotient bit per cycle,
// with divide-by-zero and signed overflow resolved in a single cycle.
module ysyx_23060136_exu2_muldiv #(
  parameter int XLEN = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  ysyx_23060136_exu2_muldiv_if.slave   io
);
  localparam int HALF = XLEN / 2;
  localparam int DW   = 2 * XLEN;
  localparam int CW   = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic [XLEN-1:0] sext_half(input logic [HALF-1:0] x);
    return {{(XLEN-HALF){x[HALF-1]}}, x};
  endfunction

  function automatic logic [XLEN-1:0] zext_half(input logic [HALF-1:0] x);
    return {{(XLEN-HALF){1'b0}}, x};
  endfunction

  function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] x);
    return neg ? -x : x;
  endfunction

  function automatic logic [DW-1:0] cond_neg_dw(input logic neg, input logic [DW-1:0] x);
    return neg ? -x : x;
  endfunction

  state_e          state_r;
  state_e          state_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [DW-1:0]   acc_r;
  logic [DW-1:0]   mcand_r;
  logic [XLEN-1:0] mplier_r;
  logic [XLEN-1:0] result_r;
  logic [2:0]      op_r;
  logic            op_w_r;
  logic            a_neg_r;
  logic            b_neg_r;
  logic            out_valid_r;

  logic            accept_s;
  logic            is_div_s;
  logic            sgn_a_s;
  logic            sgn_b_s;
  logic            a_neg_s;
  logic            b_neg_s;
  logic            div_zero_s;
  logic            ovf_s;
  logic            special_s;
  logic            stall_s;
  logic [XLEN-1:0] a_ext_s;
  logic [XLEN-1:0] b_ext_s;
  logic [XLEN-1:0] a_mag_s;
  logic [XLEN-1:0] b_mag_s;
  logic [XLEN-1:0] min_s;
  logic [XLEN-1:0] div_init_s;
  logic [XLEN-1:0] spec_raw_s;
  logic [XLEN-1:0] spec_res_s;

  logic [XLEN:0]   rem_sh_s;
  logic            rem_ge_s;
  logic [XLEN-1:0] diff_s;
  logic [DW-1:0]   acc_nxt_s;

  logic [DW-1:0]   prod_s;
  logic [XLEN-1:0] quo_s;
  logic [XLEN-1:0] rem_s;
  logic [XLEN-1:0] fix_raw_s;
  logic [XLEN-1:0] fix_res_s;

  assign accept_s = io.in_valid & (state_r == IDLE) & ~io.flush;

  // Operand views, sign/magnitude split and single-cycle special cases of the incoming op
  always_comb begin
    is_div_s = io.op[2];
    sgn_a_s  = 1'b0;
    sgn_b_s  = 1'b0;
    case (io.op)
      OP_MULH: begin
        sgn_a_s = 1'b1;
        sgn_b_s = 1'b1;
      end
      OP_MULHSU: begin
        sgn_a_s = 1'b1;
        sgn_b_s = 1'b0;
      end
      OP_DIV, OP_REM: begin
        sgn_a_s = 1'b1;
        sgn_b_s = 1'b1;
      end
      default: begin
        sgn_a_s = 1'b0;
        sgn_b_s = 1'b0;
      end
    endcase

    if (io.op_w) begin
      a_ext_s = sgn_a_s ? sext_half(io.src1[HALF-1:0]) : zext_half(io.src1[HALF-1:0]);
      b_ext_s = sgn_b_s ? sext_half(io.src2[HALF-1:0]) : zext_half(io.src2[HALF-1:0]);
      min_s   = sext_half({1'b1, {(HALF-1){1'b0}}});
    end else begin
      a_ext_s = io.src1;
      b_ext_s = io.src2;
      min_s   = {1'b1, {(XLEN-1){1'b0}}};
    end

    a_neg_s = sgn_a_s & a_ext_s[XLEN-1];
    b_neg_s = sgn_b_s & b_ext_s[XLEN-1];
    a_mag_s = cond_neg(a_neg_s, a_ext_s);
    b_mag_s = cond_neg(b_neg_s, b_ext_s);
    // A 32-bit dividend is parked in the upper half so the quotient always shifts out of bit XLEN-1
    div_init_s = io.op_w ? {a_mag_s[HALF-1:0], {HALF{1'b0}}} : a_mag_s;

    div_zero_s = is_div_s & (b_ext_s == {XLEN{1'b0}});
    ovf_s      = is_div_s & sgn_a_s & (a_ext_s == min_s) & (b_ext_s == {XLEN{1'b1}});
    special_s  = div_zero_s | ovf_s;

    if (div_zero_s) begin
      spec_raw_s = io.op[1] ? a_ext_s : {XLEN{1'b1}};
    end else begin
      spec_raw_s = io.op[1] ? {XLEN{1'b0}} : min_s;
    end
    spec_res_s = io.op_w ? sext_half(spec_raw_s[HALF-1:0]) : spec_raw_s;
  end

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    rem_sh_s = {acc_r[DW-1:XLEN], acc_r[XLEN-1]};
    rem_ge_s = (rem_sh_s >= {1'b0, mcand_r[XLEN-1:0]});
    diff_s   = rem_sh_s[XLEN-1:0] - mcand_r[XLEN-1:0];
    if (op_r[2]) begin
      if (rem_ge_s) begin
        acc_nxt_s = {diff_s, acc_r[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt_s = {rem_sh_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
      end
    end else if (mplier_r[0]) begin
      acc_nxt_s = acc_r + mcand_r;
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  // Sign correction and field selection once the iteration has finished
  always_comb begin
    prod_s = cond_neg_dw(a_neg_r ^ b_neg_r, acc_r);
    quo_s  = cond_neg(a_neg_r ^ b_neg_r, acc_r[XLEN-1:0]);
    rem_s  = cond_neg(a_neg_r, acc_r[DW-1:XLEN]);
    case (op_r)
      OP_MUL:                      fix_raw_s = op_w_r ? zext_half(prod_s[HALF-1:0]) : prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_raw_s = op_w_r ? zext_half(prod_s[XLEN-1:HALF]) : prod_s[DW-1:XLEN];
      OP_DIV, OP_DIVU:             fix_raw_s = quo_s;
      OP_REM, OP_REMU:             fix_raw_s = rem_s;
      default:                     fix_raw_s = {XLEN{1'b0}};
    endcase
    fix_res_s = op_w_r ? sext_half(fix_raw_s[HALF-1:0]) : fix_raw_s;
  end

  // Next-state logic; flush wins over every other condition
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = special_s ? DONE : BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (io.flush) begin
          state_nxt_s = IDLE;
        end else if (cnt_r == {CW{1'b0}}) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      FIX: begin
        state_nxt_s = io.flush ? IDLE : DONE;
      end
      DONE: begin
        if (io.flush || io.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture on accept and one iteration per BUSY cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= {CW{1'b0}};
      acc_r    <= {DW{1'b0}};
      mcand_r  <= {DW{1'b0}};
      mplier_r <= {XLEN{1'b0}};
      op_r     <= 3'd0;
      op_w_r   <= 1'b0;
      a_neg_r  <= 1'b0;
      b_neg_r  <= 1'b0;
    end else if (accept_s) begin
      op_r    <= io.op;
      op_w_r  <= io.op_w;
      a_neg_r <= a_neg_s;
      b_neg_r <= b_neg_s;
      cnt_r   <= io.op_w ? CW'(HALF - 1) : CW'(XLEN - 1);
      if (is_div_s) begin
        acc_r    <= {{XLEN{1'b0}}, div_init_s};
        mcand_r  <= {{XLEN{1'b0}}, b_mag_s};
        mplier_r <= {XLEN{1'b0}};
      end else begin
        acc_r    <= {DW{1'b0}};
        mcand_r  <= {{XLEN{1'b0}}, a_mag_s};
        mplier_r <= b_mag_s;
      end
    end else if ((state_r == BUSY) && !io.flush) begin
      acc_r <= acc_nxt_s;
      cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
      if (!op_r[2]) begin
        mcand_r  <= mcand_r << 1;
        mplier_r <= mplier_r >> 1;
      end
    end
  end

  // Registered result and valid flag; a flush drops the valid but keeps the last result
  always_ff @(posedge clk) begin
    if (rst) begin
      result_r    <= {XLEN{1'b0}};
      out_valid_r <= 1'b0;
    end else if (io.flush) begin
      out_valid_r <= 1'b0;
    end else if (accept_s && special_s) begin
      result_r    <= spec_res_s;
      out_valid_r <= 1'b1;
    end else if (state_r == FIX) begin
      result_r    <= fix_res_s;
      out_valid_r <= 1'b1;
    end else if ((state_r == DONE) && io.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Pipeline hold request, released in the cycle the result is taken or on flush
  always_comb begin
    stall_s = 1'b0;
    if (io.flush) begin
      stall_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:      stall_s = io.in_valid;
        BUSY, FIX: stall_s = 1'b1;
        DONE:      stall_s = ~io.out_ready;
        default:   stall_s = 1'b0;
      endcase
    end
  end

  assign io.in_ready  = (state_r == IDLE);
  assign io.out_valid = out_valid_r;
  assign io.result    = result_r;
  assign io.stall_req = stall_s;
endmodule
